// File: rtl/jellyvl_etherneco_synctimer_slave.sv
// EtherNeco sync-timer ring node: local timer, command frame parser,
// override/slew synchronisation and turnaround insertion into the response.
module jellyvl_etherneco_synctimer_slave #(
    parameter int unsigned TIMER_WIDTH     = 64,
    parameter int unsigned NUMERATOR       = 10,
    parameter int unsigned DENOMINATOR     = 3,
    parameter int unsigned MAX_NODES       = 2,
    parameter int unsigned OFFSET_WIDTH    = 24,
    parameter int unsigned ADJUST_INTERVAL = 16,
    parameter int unsigned ADJUST_LIMIT    = 1000
) (
    input  logic                           clk,
    input  logic                           reset,

    output logic [TIMER_WIDTH-1:0]         current_time,
    output logic                           synced,
    output logic signed [OFFSET_WIDTH-1:0] time_error,

    input  logic                           cmd_rx_start,
    input  logic                           cmd_rx_end,
    input  logic                           cmd_rx_error,
    input  logic [7:0]                     cmd_rx_node,
    input  logic [15:0]                    cmd_payload_pos,
    input  logic [7:0]                     cmd_payload_data,
    input  logic                           cmd_payload_valid,

    input  logic                           res_rx_start,
    input  logic [15:0]                    res_payload_pos,
    input  logic                           res_payload_valid,
    output logic [7:0]                     res_replace_data,
    output logic                           res_replace_valid
);

    localparam int unsigned TW     = TIMER_WIDTH;
    localparam int unsigned OW     = OFFSET_WIDTH;
    localparam int unsigned FRAC_W = (DENOMINATOR > 1) ? $clog2(2 * DENOMINATOR) : 1;
    localparam int unsigned ADJ_W  = (ADJUST_INTERVAL > 1) ? $clog2(ADJUST_INTERVAL) : 1;

    localparam logic [TW-1:0]         INC_INT   = TW'(NUMERATOR / DENOMINATOR);
    localparam logic [FRAC_W-1:0]     FRAC_STEP = FRAC_W'(NUMERATOR % DENOMINATOR);
    localparam logic [FRAC_W-1:0]     FRAC_DEN  = FRAC_W'(DENOMINATOR);
    localparam logic [ADJ_W-1:0]      ADJ_LAST  = ADJ_W'(ADJUST_INTERVAL - 1);
    localparam logic signed [OW-1:0]  LIMIT_P   = OW'(ADJUST_LIMIT);
    localparam logic signed [OW-1:0]  LIMIT_N   = -LIMIT_P;

    // timer / slew state
    logic [FRAC_W-1:0]     frac;
    logic [ADJ_W-1:0]      adj_cnt;
    logic signed [OW-1:0]  adj_remaining;

    // frame capture state
    logic [TW-1:0]         t_rx;
    logic [7:0]            my_node;
    logic [63:0]           master_time;
    logic [OW-1:0]         offset;
    logic [1:0]            flags;
    logic                  frame_ok;
    logic                  got_time;
    logic [OW-1:0]         turnaround;

    // combinational helpers
    logic [FRAC_W-1:0]     frac_sum;
    logic                  carry;
    logic [FRAC_W-1:0]     frac_next;
    logic [TW-1:0]         time_inc;
    logic                  slew_tick;
    logic                  node_in_range;
    logic [OW-1:0]         eff_offset;
    logic [TW-1:0]         sum_time;
    logic [TW-1:0]         override_time;
    logic signed [OW-1:0]  err;
    logic signed [OW-1:0]  err_clamped;
    logic                  accept;
    logic [15:0]           pos_off;
    logic                  off_hit;
    logic [2:0]            mt_idx;
    logic [OW-1:0]         off_mask;
    logic [OW-1:0]         off_data;
    logic [15:0]           res_off;

    // Increment, slew tick, accept decision and sync arithmetic
    always_comb begin
        frac_sum      = frac + FRAC_STEP;
        carry         = (frac_sum >= FRAC_DEN);
        frac_next     = carry ? (frac_sum - FRAC_DEN) : frac_sum;
        time_inc      = INC_INT + TW'(carry);
        slew_tick     = (adj_cnt == ADJ_LAST);

        node_in_range = (32'(my_node) < MAX_NODES);
        eff_offset    = node_in_range ? offset : '0;
        sum_time      = TW'(master_time) + TW'(eff_offset);
        override_time = sum_time + (current_time - t_rx) + time_inc;
        err           = OW'(sum_time - t_rx);
        err_clamped   = err;
        if (err > LIMIT_P) begin
            err_clamped = LIMIT_P;
        end else if (err < LIMIT_N) begin
            err_clamped = LIMIT_N;
        end
        accept        = cmd_rx_end && frame_ok && got_time && !cmd_rx_error;
    end

    // Payload byte decode: master time lane and own offset slot lane
    always_comb begin
        pos_off  = cmd_payload_pos - 16'd9;
        off_hit  = (cmd_payload_pos >= 16'd9) && (pos_off[15:2] == 14'(my_node));
        mt_idx   = 3'(cmd_payload_pos - 16'd1);
        off_mask = OW'(32'h0000_00ff << {pos_off[1:0], 3'b000});
        off_data = OW'(32'(cmd_payload_data) << {pos_off[1:0], 3'b000});
    end

    // Local timer with fractional carry, slew steps and sync actions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_time  <= '0;
            frac          <= '0;
            adj_cnt       <= '0;
            adj_remaining <= '0;
            synced        <= 1'b0;
            time_error    <= '0;
        end else begin
            frac    <= frac_next;
            adj_cnt <= slew_tick ? '0 : adj_cnt + ADJ_W'(1);
            if (accept && flags[1]) begin
                current_time  <= override_time;
                adj_remaining <= '0;
                synced        <= 1'b1;
            end else if (accept && flags[0]) begin
                current_time  <= current_time + time_inc;
                time_error    <= err;
                adj_remaining <= err_clamped;
            end else if (slew_tick && !adj_remaining[OW-1] && (adj_remaining != '0)) begin
                current_time  <= current_time + time_inc + TW'(1);
                adj_remaining <= adj_remaining - OW'(1);
            end else if (slew_tick && adj_remaining[OW-1]) begin
                current_time  <= current_time + time_inc - TW'(1);
                adj_remaining <= adj_remaining + OW'(1);
            end else begin
                current_time  <= current_time + time_inc;
            end
        end
    end

    // Command frame capture; an error pulse always wins and discards the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_rx        <= '0;
            my_node     <= '0;
            master_time <= '0;
            offset      <= '0;
            flags       <= '0;
            frame_ok    <= 1'b0;
            got_time    <= 1'b0;
        end else begin
            if (cmd_rx_start) begin
                t_rx        <= current_time;
                my_node     <= cmd_rx_node;
                master_time <= '0;
                offset      <= '0;
                flags       <= '0;
                frame_ok    <= 1'b1;
                got_time    <= 1'b0;
            end else if (cmd_payload_valid) begin
                if (cmd_payload_pos == 16'd0) begin
                    flags <= cmd_payload_data[1:0];
                end
                if ((cmd_payload_pos >= 16'd1) && (cmd_payload_pos <= 16'd8)) begin
                    master_time[{mt_idx, 3'b000} +: 8] <= cmd_payload_data;
                end
                if (cmd_payload_pos == 16'd8) begin
                    got_time <= 1'b1;
                end
                if (off_hit) begin
                    offset <= (offset & ~off_mask) | (off_data & off_mask);
                end
            end
            if (cmd_rx_error) begin
                frame_ok <= 1'b0;
            end
        end
    end

    // Turnaround since the latest command start, latched at response start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turnaround <= '0;
        end else if (res_rx_start) begin
            turnaround <= OW'(current_time - t_rx);
        end
    end

    // Replace own offset slot of the response with the turnaround bytes
    always_comb begin
        res_off           = res_payload_pos - 16'd9;
        res_replace_valid = 1'b0;
        res_replace_data  = 8'h00;
        if (res_payload_valid && (res_payload_pos >= 16'd9)
                && (res_off[15:2] == 14'(my_node)) && node_in_range) begin
            res_replace_valid = 1'b1;
            res_replace_data  = 8'(32'(turnaround) >> {res_off[1:0], 3'b000});
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_slave.sv
// Directed bench for the EtherNeco sync-timer slave node.
module tb_jellyvl_etherneco_synctimer_slave;

    logic        clk;
    logic        reset;
    logic [63:0] current_time;
    logic        synced;
    logic [23:0] time_error;
    logic        cmd_rx_start;
    logic        cmd_rx_end;
    logic        cmd_rx_error;
    logic [7:0]  cmd_rx_node;
    logic [15:0] cmd_payload_pos;
    logic [7:0]  cmd_payload_data;
    logic        cmd_payload_valid;
    logic        res_rx_start;
    logic [15:0] res_payload_pos;
    logic        res_payload_valid;
    logic [7:0]  res_replace_data;
    logic        res_replace_valid;

    int n_total = 0;
    int n_pass  = 0;

    longint unsigned ncyc;
    logic [63:0]     tb_off;
    logic [63:0]     tb_trx;

    jellyvl_etherneco_synctimer_slave dut (
        .clk               (clk),
        .reset             (reset),
        .current_time      (current_time),
        .synced            (synced),
        .time_error        (time_error),
        .cmd_rx_start      (cmd_rx_start),
        .cmd_rx_end        (cmd_rx_end),
        .cmd_rx_error      (cmd_rx_error),
        .cmd_rx_node       (cmd_rx_node),
        .cmd_payload_pos   (cmd_payload_pos),
        .cmd_payload_data  (cmd_payload_data),
        .cmd_payload_valid (cmd_payload_valid),
        .res_rx_start      (res_rx_start),
        .res_payload_pos   (res_payload_pos),
        .res_payload_valid (res_payload_valid),
        .res_replace_data  (res_replace_data),
        .res_replace_valid (res_replace_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clock edges since the last reset release
    always @(posedge clk or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // nominal 10/3 timer plus accumulated sync offset
    function automatic logic [63:0] exp_time();
        return tb_off + 64'((ncyc * 10) / 3);
    endfunction

    function automatic logic [7:0] payload_byte(input int p, input logic [7:0] fl,
            input logic [63:0] mt, input logic [31:0] o0, input logic [31:0] o1);
        logic [7:0] b;
        b = 8'h00;
        if (p == 0)       b = fl;
        else if (p <= 8)  b = mt[8*(p-1) +: 8];
        else if (p <= 12) b = o0[8*(p-9) +: 8];
        else if (p <= 16) b = o1[8*(p-13) +: 8];
        return b;
    endfunction

    task automatic send_frame(input logic [7:0] node, input logic [7:0] fl, input logic [63:0] mt,
            input logic [31:0] o0, input logic [31:0] o1, input int nbytes,
            input bit err_mid, input bit err_end);
        cmd_rx_start = 1'b1;
        cmd_rx_node  = node;
        tb_trx       = exp_time();
        @(negedge clk);
        cmd_rx_start = 1'b0;
        for (int p = 0; p < nbytes; p++) begin
            cmd_payload_pos   = 16'(p);
            cmd_payload_data  = payload_byte(p, fl, mt, o0, o1);
            cmd_payload_valid = 1'b1;
            cmd_rx_error      = err_mid && (p == 3);
            @(negedge clk);
        end
        cmd_payload_valid = 1'b0;
        cmd_rx_error      = err_end;
        cmd_rx_end        = 1'b1;
        @(negedge clk);
        cmd_rx_end   = 1'b0;
        cmd_rx_error = 1'b0;
    endtask

    task automatic res_probe(input string tag, input logic [15:0] pos, input logic [8:0] exp);
        res_payload_pos   = pos;
        res_payload_valid = 1'b1;
        #1;
        check(tag, {55'd0, res_replace_valid, res_replace_data}, {55'd0, exp});
        @(negedge clk);
        res_payload_valid = 1'b0;
    endtask

    logic [63:0] ft [6];
    logic [63:0] mt;

    initial begin
        ft = '{64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20};
        tb_off = '0;
        tb_trx = '0;
        reset = 1'b1;
        cmd_rx_start = 0; cmd_rx_end = 0; cmd_rx_error = 0; cmd_rx_node = 0;
        cmd_payload_pos = 0; cmd_payload_data = 0; cmd_payload_valid = 0;
        res_rx_start = 0; res_payload_pos = 0; res_payload_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_time",   current_time, 64'd0);
        check("rst_synced", {63'd0, synced}, 64'd0);
        check("rst_err",    {40'd0, time_error}, 64'd0);
        check("rst_repl",   {55'd0, res_replace_valid, res_replace_data}, 64'd0);
        reset = 1'b0;

        // free run 10/3 per clock
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("freerun", current_time, ft[i]);
        end

        // override, node 1, slot 0 junk must be ignored
        send_frame(8'd1, 8'h02, 64'h1000, 32'h5555_5555, 32'h20, 17, 1'b0, 1'b0);
        check("ovr_time", current_time, 64'h105F);
        check("ovr_synced", {63'd0, synced}, 64'd1);
        tb_off = tb_off + 64'h1020 - tb_trx;
        @(negedge clk);
        check("ovr_next", current_time, exp_time());

        // correct +5: slews one unit per 16 clocks
        mt = exp_time() + 64'd5;
        send_frame(8'd0, 8'h01, mt, 32'h0, 32'h0, 9, 1'b0, 1'b0);
        check("cor5_err", {40'd0, time_error}, 64'd5);
        check("cor5_end", current_time, exp_time());
        repeat (16) @(negedge clk);
        check("cor5_16", current_time, exp_time() + 64'd1);
        repeat (64) @(negedge clk);
        check("cor5_80", current_time, exp_time() + 64'd5);
        repeat (32) @(negedge clk);
        check("cor5_112", current_time, exp_time() + 64'd5);
        tb_off = tb_off + 64'd5;

        // discarded frames: error mid-frame, error on end, short frame
        send_frame(8'd0, 8'h02, 64'h0, 32'h0, 32'h0, 9, 1'b1, 1'b0);
        check("errmid_time", current_time, exp_time());
        check("errmid_synced", {63'd0, synced}, 64'd1);
        send_frame(8'd0, 8'h02, 64'h0, 32'h0, 32'h0, 9, 1'b0, 1'b1);
        check("errend_time", current_time, exp_time());
        send_frame(8'd0, 8'h02, 64'h0, 32'h0, 32'h0, 5, 1'b0, 1'b0);
        check("short_time", current_time, exp_time());

        // response turnaround: res start 15 clocks (50 units) after cmd start
        cmd_rx_start = 1'b1;
        cmd_rx_node  = 8'd0;
        @(negedge clk);
        cmd_rx_start = 1'b0;
        repeat (14) @(negedge clk);
        res_rx_start = 1'b1;
        @(negedge clk);
        res_rx_start = 1'b0;
        res_probe("res_p8",  16'd8,  9'h000);
        res_probe("res_p9",  16'd9,  9'h132);
        res_probe("res_p10", 16'd10, 9'h100);
        res_probe("res_p11", 16'd11, 9'h100);
        res_probe("res_p12", 16'd12, 9'h100);
        res_probe("res_p13", 16'd13, 9'h000);
        res_payload_pos = 16'd9;
        #1;
        check("res_novalid", {55'd0, res_replace_valid, res_replace_data}, 64'd0);

        // node beyond MAX_NODES never replaces
        @(negedge clk);
        cmd_rx_start = 1'b1;
        cmd_rx_node  = 8'd2;
        @(negedge clk);
        cmd_rx_start = 1'b0;
        res_probe("res_node2_p17", 16'd17, 9'h000);
        res_probe("res_node2_p9",  16'd9,  9'h000);

        // correct -2000: error reported, slew clamped to -1000
        mt = exp_time() - 64'd2000;
        send_frame(8'd0, 8'h01, mt, 32'h0, 32'h0, 9, 1'b0, 1'b0);
        check("corn_err", {40'd0, time_error}, 64'hFFF830);
        check("corn_end", current_time, exp_time());
        repeat (16) @(negedge clk);
        check("corn_16", current_time, exp_time() - 64'd1);
        repeat (16) @(negedge clk);
        check("corn_32", current_time, exp_time() - 64'd2);

        // reset in the middle of a frame
        cmd_rx_start = 1'b1;
        cmd_rx_node  = 8'd1;
        @(negedge clk);
        cmd_rx_start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            cmd_payload_pos   = 16'(p);
            cmd_payload_data  = payload_byte(p, 8'h02, 64'h3000, 32'h0, 32'h0);
            cmd_payload_valid = 1'b1;
            @(negedge clk);
        end
        cmd_payload_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mrst_time",   current_time, 64'd0);
        check("mrst_synced", {63'd0, synced}, 64'd0);
        check("mrst_err",    {40'd0, time_error}, 64'd0);
        check("mrst_repl",   {55'd0, res_replace_valid, res_replace_data}, 64'd0);
        reset  = 1'b0;
        tb_off = '0;
        @(negedge clk);
        check("mrst_run", current_time, 64'd3);
        send_frame(8'd1, 8'h02, 64'h2000, 32'h0, 32'h10, 17, 1'b0, 1'b0);
        tb_off = tb_off + 64'h2010 - tb_trx;
        check("mrst_ovr_time", current_time, exp_time());
        check("mrst_ovr_synced", {63'd0, synced}, 64'd1);
        @(negedge clk);
        check("mrst_ovr_next", current_time, exp_time());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
